// File: rtl/enc_link_arbiter.sv
// Round-robin owner scheduler for the shared encoded link: 8 sources, grant held
// until done/release, preempted after MAX_HOLD cycles when others are waiting.
module enc_link_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNTW     = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [7:0]      req,
  input  logic            EN_done,
  output logic            RDY_grant,
  output logic [2:0]      grant_idx,
  output logic [7:0]      grant_onehot,
  output logic            mv_busy,
  output logic            mv_preempt,
  output logic [CNTW-1:0] grant_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [2:0]      owner_q, owner_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic            rdy_q, rdy_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      onehot_q, onehot_d;
  logic            preempt_q, preempt_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [2:0] sel, scan;
  logic       sel_vld, release_c, timeout_c;

  // Descending scan so the requester closest to rr_ptr is the last one written.
  always_comb begin
    sel  = 3'd0;
    scan = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      scan = rr_ptr_q + 3'(k);
      if (req[scan]) sel = scan;
    end
    sel_vld = |req;
  end

  assign release_c = EN_done | ~req[owner_q];
  assign timeout_c = (hold_cnt_q == HOLD_LIM) && |(req & ~onehot_q);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    rdy_d      = rdy_q;
    idx_d      = idx_q;
    onehot_d   = onehot_q;
    preempt_d  = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      GRANT: begin
        hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
        if (release_c || timeout_c) begin
          state_d   = GAP;
          preempt_d = ~release_c;
          rr_ptr_d  = owner_q + 3'd1;
          cnt_d     = cnt_q + CNTW'(1);
          rdy_d     = 1'b0;
          idx_d     = 3'd0;
          onehot_d  = 8'd0;
        end
      end
      default: begin
        if (sel_vld) begin
          state_d    = GRANT;
          owner_d    = sel;
          idx_d      = sel;
          onehot_d   = 8'b1 << sel;
          rdy_d      = 1'b1;
          hold_cnt_d = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 3'd0;
      owner_q    <= 3'd0;
      hold_cnt_q <= 8'd0;
      rdy_q      <= 1'b0;
      idx_q      <= 3'd0;
      onehot_q   <= 8'd0;
      preempt_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      rdy_q      <= rdy_d;
      idx_q      <= idx_d;
      onehot_q   <= onehot_d;
      preempt_q  <= preempt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign RDY_grant    = rdy_q;
  assign grant_idx    = idx_q;
  assign grant_onehot = onehot_q;
  assign mv_preempt   = preempt_q;
  assign grant_cnt    = cnt_q;
  assign mv_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_enc_link_arbiter.sv
// Randomized + directed bench for enc_link_arbiter against a cycle-level
// behavioural model of owner/gap/pointer bookkeeping.
module tb_enc_link_arbiter;

  localparam int MAXH = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] req = 8'd0;
  logic       EN_done = 1'b0;
  logic       RDY_grant, mv_busy, mv_preempt;
  logic [2:0] grant_idx;
  logic [7:0] grant_onehot, grant_cnt;

  enc_link_arbiter #(.MAX_HOLD(MAXH), .CNTW(8)) dut (
    .CLK(CLK), .RST(RST), .req(req), .EN_done(EN_done),
    .RDY_grant(RDY_grant), .grant_idx(grant_idx), .grant_onehot(grant_onehot),
    .mv_busy(mv_busy), .mv_preempt(mv_preempt), .grant_cnt(grant_cnt)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner (-1 = no grant), gap flag, scan pointer, age of current grant.
  int m_owner = -1, m_gap = 0, m_ptr = 0, m_age = 0, m_cnt = 0, m_pre = 0;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_owner = -1; m_gap = 0; m_ptr = 0; m_age = 0; m_cnt = 0; m_pre = 0;
    end else if (m_owner >= 0) begin
      int rel, tmo;
      rel = (EN_done || !req[m_owner]) ? 1 : 0;
      tmo = (m_age == MAXH - 1 && (req & ~(8'd1 << m_owner)) != 0) ? 1 : 0;
      if (rel || tmo) begin
        m_ptr   = (m_owner + 1) % 8;
        m_cnt   = (m_cnt + 1) % 256;
        m_pre   = rel ? 0 : 1;
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_pre = 0;
        if (m_age < 255) m_age++;
      end
    end else begin
      m_pre = 0;
      m_gap = 0;
      if (req != 0) begin
        m_owner = pick(req, m_ptr);
        m_age   = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      int rdy;
      rdy = (m_owner >= 0) ? 1 : 0;
      chk("RDY_grant", RDY_grant, rdy);
      chk("grant_idx", grant_idx, rdy ? m_owner : 0);
      chk("grant_onehot", grant_onehot, rdy ? (1 << m_owner) : 0);
      chk("mv_busy", mv_busy, (rdy || m_gap) ? 1 : 0);
      chk("mv_preempt", mv_preempt, m_pre);
      chk("grant_cnt", grant_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    req = 8'd0; EN_done = 1'b0; RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_rdy", RDY_grant, 0);
    chk("rst_busy", mv_busy, 0);
    chk("rst_cnt", grant_cnt, 0);

    // Single request, completion, and scan continuing after the released owner
    req = 8'h20; tick();
    chk("single_rdy", RDY_grant, 1);
    chk("single_idx", grant_idx, 5);
    chk("single_oh", grant_onehot, 8'h20);
    EN_done = 1'b1; tick(); EN_done = 1'b0;
    chk("gap_rdy", RDY_grant, 0);
    chk("gap_busy", mv_busy, 1);
    chk("gap_cnt", grant_cnt, 1);
    req = 8'h00; tick();
    chk("idle_busy", mv_busy, 0);
    req = 8'h61; tick();
    chk("next_scan_idx", grant_idx, 6);
    req = 8'h00; tick(); tick();

    // Round robin over all sources
    do_reset();
    req = 8'hFF; tick();
    for (int g = 0; g < 9; g++) begin
      chk("rr_idx", grant_idx, g % 8);
      EN_done = 1'b1; tick(); EN_done = 1'b0;
      chk("rr_gap_rdy", RDY_grant, 0);
      tick();
    end
    chk("rr_cnt", grant_cnt, 9);
    req = 8'h00; tick(); tick();

    // Preemption ping-pong between two sources
    do_reset();
    req = 8'h03; tick();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        chk("pre_hold_idx", grant_idx, r);
      end
      tick();
      chk("pre_pulse", mv_preempt, 1);
      chk("pre_gap_rdy", RDY_grant, 0);
      tick();
      chk("pre_pulse_end", mv_preempt, 0);
      chk("pre_next_idx", grant_idx, (r + 1) % 2);
    end
    req = 8'h00; tick(); tick();

    // Lone owner never preempted, then release colliding with timeout
    do_reset();
    req = 8'h01; tick();
    for (int c = 0; c < 20; c++) begin
      chk("lone_rdy", RDY_grant, 1);
      chk("lone_pre", mv_preempt, 0);
      tick();
    end
    req = 8'h00; tick(); tick();
    req = 8'h03; tick();
    chk("coll_idx", grant_idx, 1);
    tick(); tick(); tick();
    EN_done = 1'b1; tick(); EN_done = 1'b0;
    chk("coll_pre", mv_preempt, 0);
    chk("coll_busy", mv_busy, 1);
    tick();
    chk("coll_next", grant_idx, 0);
    req = 8'h00; tick(); tick();

    // Drop-release with pointer wrap
    do_reset();
    req = 8'h80; tick();
    chk("wrap_own", grant_idx, 7);
    req = 8'h01; tick();
    chk("wrap_gap", RDY_grant, 0);
    tick();
    chk("wrap_idx", grant_idx, 0);
    req = 8'h00; tick(); tick();

    // Async reset in the middle of a grant
    do_reset();
    req = 8'h01; tick(); EN_done = 1'b1; tick(); EN_done = 1'b0;
    req = 8'h08; tick();
    chk("mid_own", grant_idx, 3);
    req = 8'h18;
    #3 RST = 1'b1;
    #1;
    chk("async_rdy", RDY_grant, 0);
    chk("async_idx", grant_idx, 0);
    chk("async_oh", grant_onehot, 0);
    chk("async_cnt", grant_cnt, 0);
    chk("async_busy", mv_busy, 0);
    tick(); RST = 1'b0;
    tick();
    chk("post_rst_idx", grant_idx, 3);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 3))
        0: req = 8'($urandom);
        1: req = 8'd1 << $urandom_range(0, 7);
        2: req = req;
        default: req = 8'($urandom) & 8'($urandom);
      endcase
      EN_done = ($urandom_range(0, 5) == 0);
      tick();
    end
    req = 8'h00; EN_done = 1'b0; tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/enc_link_arbiter.md
Name: enc_link_arbiter

Overview:
- Round-robin scheduler that shares the single encoded transmission link between 8 requesting sources.
- Each cycle it selects at most one owner.
- It presents the owner as a 3-bit index (the encoder's a2..a0 form) plus a one-hot vector.
- It holds the grant until the owner completes or releases, and preempts a grant that overstays when other sources are waiting.
- Sits between the source request lines and the link encoder/driver.

Parameters:
- MAX_HOLD, 8, max cycles one grant may be held while other requests pend. Legal range 1..255; 8-bit compare.
- CNTW, 8, width of the issued-grant counter.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i = source i wants the link; level-sensitive.
- EN_done  input  1  one-cycle pulse from the link: current owner's transfer complete.
- RDY_grant  output  1  grant valid.
- grant_idx  output  3  encoded owner index; 0 when RDY_grant=0.
- grant_onehot  output  8  one-hot owner; 0 when RDY_grant=0.
- mv_busy  output  1  state != IDLE.
- mv_preempt  output  1  one-cycle pulse: grant revoked by hold timeout.
- grant_cnt  output  CNTW  count of completed or ended grants; wraps.

Behaviour:
- All outputs registered except mv_busy, which is decoded from the state register.
- Reset (async, any time): state=IDLE, rr_ptr=0, owner=0, hold_cnt=0, RDY_grant=0, grant_idx=0, grant_onehot=0, mv_preempt=0, grant_cnt=0.
- Selection (combinational):
  - sel = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod 8.
  - Valid only if req != 0.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0: next edge -> GRANT; owner<=sel; grant_idx<=sel; grant_onehot<=1<<sel; RDY_grant<=1; hold_cnt<=0.
  - Else stay in IDLE.
  - Latency: request visible before edge N gives RDY_grant=1 after edge N.
- GRANT:
  - hold_cnt increments each cycle, saturating at 255.
  - Release: EN_done=1 OR req[owner]=0 -> GAP.
  - Preempt: hold_cnt == MAX_HOLD-1 AND (req & ~grant_onehot) != 0 AND no release this cycle -> GAP, with mv_preempt=1 for exactly the next cycle.
  - Release and preempt in the same cycle: release wins; mv_preempt stays 0.
  - Timeout with no other requester: no preempt; grant continues indefinitely.
  - On any exit: rr_ptr<=owner+1 mod 8 (wraps 7->0); grant_cnt<=grant_cnt+1 (wraps); RDY_grant, grant_idx, grant_onehot <= 0.
- GAP:
  - Exactly one turnaround cycle with outputs deasserted and mv_busy=1.
  - Same decision as IDLE: req != 0 -> GRANT with new selection; else -> IDLE.
  - A released owner still requesting is considered last, because rr_ptr has advanced past it.
- EN_done outside GRANT is ignored.
- req changes in GAP/IDLE take effect at the next selection only.
- Minimum spacing: two back-to-back grants are separated by one deasserted cycle (GRANT -> GAP -> GRANT).

Test Plan:
- Reset / single request:
  - Apply RST, release.
  - req=0x20 -> after next edge RDY_grant=1, grant_idx=5, grant_onehot=0x20.
  - Pulse EN_done -> one GAP cycle with RDY_grant=0, mv_busy=1, then IDLE with mv_busy=0.
  - Checks: grant_cnt=1, next scan starts at 6.
- Round robin:
  - req=0xFF held; EN_done pulsed on each grant's first cycle.
  - grant_idx sequence 0,1,2,3,4,5,6,7,0 with one GAP between each.
  - grant_cnt=9 after the ninth grant.
- Preempt:
  - MAX_HOLD=4, req=0x03, no EN_done.
  - Owner 0 held 4 cycles; mv_preempt pulses once; GAP; then grant_idx=1.
  - Owner 1 likewise preempted; grant returns to 0.
- Lone owner and collision:
  - req=0x01 for 20 cycles, no EN_done -> RDY_grant stays 1, grant_idx=0, mv_preempt never asserts.
  - Separately, EN_done coincident with the timeout cycle -> exit to GAP with mv_preempt=0.
- Drop-release / wrap:
  - Owner 7 granted; deassert req[7] with req=0x01 -> GAP, then grant_idx=0 (rr_ptr wrapped 7->0).
- Reset mid-grant:
  - Assert RST asynchronously while owner=3.
  - Outputs go 0 immediately, without waiting for an edge.
  - After release with req=0x18, grant_idx=3 (rr_ptr reset to 0).
